uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 SHALL have the port clk, input, 1 bit: system clock.
REQ-003 SHALL have the port reset, input, 1 bit: asynchronous reset, active high.
REQ-004 SHALL have the port tick16, input, 1 bit: one-clk pulse at 16x the baud rate, from the baud generator.
REQ-005 SHALL have the port RX, input, 1 bit: serial line, asynchronous to clk, idles high.
REQ-006 SHALL have the port SPEN, input, 1 bit: serial port enable.
REQ-007 SHALL have the port CREN, input, 1 bit: continuous receive enable.
REQ-008 SHALL have the port RD, input, 1 bit: one-clk read strobe from the CPU.
REQ-009 SHALL have the port RX_data, output, 32 bits: RCREG zero-extended to 32 bits, with bits 31:8 = 0.
REQ-010 SHALL have the port RCIF, output, 1 bit: receive buffer full flag.
REQ-011 SHALL have the port FERR, output, 1 bit: framing error flag for the byte in RCREG.
REQ-012 SHALL have the port OERR, output, 1 bit: overrun error flag, sticky.
REQ-013 SHALL have the port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-014 SHALL pass RX through a 2-flop synchronizer with both flops reset to 1; rx_s denotes the synchronizer output, and all decisions SHALL use rx_s.
REQ-015 SHALL implement an FSM with states IDLE, START, DATA and STOP, a 4-bit tick counter and a 3-bit bit index; the counter SHALL advance only on tick16.
REQ-016 IDLE: when SPEN=1, CREN=1 and rx_s=0, the FSM SHALL go to START with the tick counter cleared.
REQ-017 START: on the 8th tick16 (mid-bit), if rx_s=0 the FSM SHALL go to DATA with the counter cleared; otherwise (false start) it SHALL return to IDLE with no flag change.
REQ-018 DATA: every 16th tick16, rx_s SHALL be shifted in LSB first; after bit 7 the FSM SHALL go to STOP.
REQ-019 STOP: on the 16th tick16, rx_s SHALL be sampled as the stop bit and the FSM SHALL return to IDLE in the same clk.
REQ-020 The byte SHALL be transferred to RCREG on the clk following the stop sample, latency 1 clk.
REQ-021 On transfer with RCIF=0: RCREG SHALL take the byte, FERR SHALL take ~stop_bit, and RCIF SHALL be set to 1.
REQ-022 On transfer with RCIF=1 and RD=0: the byte SHALL be discarded, RCREG/FERR SHALL be unchanged, and OERR SHALL be set to 1.
REQ-023 Transfer and RD in the same clk SHALL load the new byte, leave RCIF=1 and leave OERR unchanged.
REQ-024 RD alone SHALL clear RCIF in the next clk; RD with RCIF=0 SHALL have no effect; RX_data SHALL remain readable.
REQ-025 OERR SHALL be cleared only by CREN=0 or by reset.
REQ-026 While OERR=1, IDLE SHALL NOT accept a new start bit.
REQ-027 CREN=0 or SPEN=0 in any state SHALL abort to IDLE in the next clk, discard the partial byte, and leave RCREG/RCIF/FERR unchanged.
REQ-028 An RX low level held beyond the stop bit SHALL give FERR=1 with byte 0x00; the FSM SHALL NOT restart until rx_s has been observed high in IDLE.

Reset
REQ-029 Asserting reset SHALL immediately force: FSM=IDLE, counters=0, RCREG=0x00, RX_data=0, RCIF=0, FERR=0, OERR=0, busy=0, synchronizer=1.
REQ-030 Reset mid-frame SHALL discard the frame; after reset deasserts, reception SHALL resume only on the next falling edge of rx_s.

Verification
REQ-031 SHALL cover: SPEN=CREN=1, frame for 0xA5 with stop=1 -> RCIF=1, RX_data=0x000000A5, FERR=0 one clk after the stop sample; after RD, RCIF=0.
REQ-032 SHALL cover: a 0x3C frame with stop=0 -> RX_data=0x0000003C, FERR=1, RCIF=1.
REQ-033 SHALL cover: frames 0x11 then 0x22 with no RD -> RX_data=0x11, OERR=1; after CREN low for 1 clk, OERR=0 and 0x33 is then received normally.
REQ-034 SHALL cover: an RX low glitch of 4 tick16 periods -> FSM returns to IDLE, RCIF stays 0, busy pulses.
REQ-035 SHALL cover: RD coincident with the transfer of 0x55 while RCIF=1 -> RX_data=0x55, RCIF=1, OERR=0.
REQ-036 SHALL cover: reset asserted at DATA bit 4 -> all outputs zero asynchronously; the next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver with a single-byte receive buffer (RCREG).
// Status flags: RCIF (buffer full), FERR (framing error), OERR (sticky overrun).
module uart_receiver (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick16,
  input  logic        RX,
  input  logic        SPEN,
  input  logic        CREN,
  input  logic        RD,
  output logic [31:0] RX_data,
  output logic        RCIF,
  output logic        FERR,
  output logic        OERR,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0] state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic [7:0] rcreg;
  logic       rx_meta;
  logic       rx_s;
  logic       stop_bit;
  logic       xfer_pend;
  logic       armed;
  logic       enable;
  logic       start_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // armed: the line has been seen high while idle, so a low level is a real
  // falling edge and not a stuck-low line or the tail of a broken frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) armed <= 1'b0;
    else       armed <= (state == IDLE) && (armed || rx_s);
  end

  assign enable   = SPEN && CREN;
  assign start_ok = enable && !OERR && armed && !rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= 4'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
      stop_bit  <= 1'b0;
      xfer_pend <= 1'b0;
    end else begin
      xfer_pend <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        tick_cnt <= 4'd0;
        bit_idx  <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              state    <= START;
              tick_cnt <= 4'd0;
            end
          end
          START: begin
            if (tick16) begin
              if (tick_cnt == 4'd7) begin
                tick_cnt <= 4'd0;
                bit_idx  <= 3'd0;
                state    <= rx_s ? IDLE : DATA;
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (tick16) begin
              if (tick_cnt == 4'd15) begin
                tick_cnt  <= 4'd0;
                shift_reg <= {rx_s, shift_reg[7:1]};
                if (bit_idx == 3'd7) begin
                  bit_idx <= 3'd0;
                  state   <= STOP;
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                end
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          STOP: begin
            if (tick16) begin
              if (tick_cnt == 4'd15) begin
                tick_cnt  <= 4'd0;
                stop_bit  <= rx_s;
                xfer_pend <= 1'b1;
                state     <= IDLE;
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Buffer handshake: RCIF is "valid", RD is the one-clk "taken" strobe.
  // A completed byte loads only if the buffer is empty or is read in that
  // same clk; otherwise it is dropped and OERR latches until CREN goes low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcreg <= 8'd0;
      RCIF  <= 1'b0;
      FERR  <= 1'b0;
      OERR  <= 1'b0;
    end else begin
      if (xfer_pend) begin
        if (!RCIF || RD) begin
          rcreg <= shift_reg;
          FERR  <= ~stop_bit;
          RCIF  <= 1'b1;
        end else begin
          OERR <= 1'b1;
        end
      end else if (RD) begin
        RCIF <= 1'b0;
      end
      if (!CREN) OERR <= 1'b0;
    end
  end

  assign RX_data   = {24'd0, rcreg};
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: vector table of whole frames plus
// hand-written sequences for overrun, glitch, read/transfer collision, reset and abort.
module tb_uart_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick16;
  logic        RX;
  logic        SPEN;
  logic        CREN;
  logic        RD;
  logic [31:0] RX_data;
  logic        RCIF;
  logic        FERR;
  logic        OERR;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic        stop_seen;
  logic        cap_rcif_fall;
  logic        cap_rcif;
  logic [31:0] cap_data;
  logic        cap_ferr;
  logic        cap_oerr;
  logic        busy_seen;
  logic        hold_busy;
  logic [1:0]  tdiv;

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  uart_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .tick16    (tick16),
    .RX        (RX),
    .SPEN      (SPEN),
    .CREN      (CREN),
    .RD        (RD),
    .RX_data   (RX_data),
    .RCIF      (RCIF),
    .FERR      (FERR),
    .OERR      (OERR),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / tick16 every 4th clk / busy monitor
  always #5 clk = ~clk;

  initial begin
    tdiv   = 2'd0;
    tick16 = 1'b0;
    forever begin
      @(negedge clk);
      tdiv   = tdiv + 2'd1;
      tick16 = (tdiv == 2'd0);
    end
  end

  initial begin
    busy_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives start + 8 data bits (64 clk each), then the stop level; captures
  // flags at the clk where busy drops and one clk later (after the transfer).
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic rd_at_xfer, input int hold);
    logic [8:0] bits;
    bits      = {d, 1'b0};
    stop_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      RX = bits[i];
      repeat (64) @(negedge clk);
    end
    RX = stop;
    for (int i = 0; i < 96 && !stop_seen; i++) begin
      @(negedge clk);
      if (!busy) stop_seen = 1'b1;
    end
    check("stop_seen", {31'd0, stop_seen}, 32'd1);
    cap_rcif_fall = RCIF;
    if (rd_at_xfer) RD = 1'b1;
    @(negedge clk);
    RD       = 1'b0;
    cap_rcif = RCIF;
    cap_data = RX_data;
    cap_ferr = FERR;
    cap_oerr = OERR;
    busy_seen = 1'b0;
    repeat (hold) @(negedge clk);
    hold_busy = busy_seen;
    RX = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  task automatic pulse_rd();
    RD = 1'b1;
    @(negedge clk);
    RD = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_data: 8'h3C, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h6B, stop: 1'b0, exp_data: 8'h6B, exp_ferr: 1'b1};

    reset = 1'b1;
    RX    = 1'b1;
    SPEN  = 1'b1;
    CREN  = 1'b1;
    RD    = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_rx_data", RX_data, 32'd0);
    check("rst_rcif", {31'd0, RCIF}, 32'd0);
    check("rst_ferr", {31'd0, FERR}, 32'd0);
    check("rst_oerr", {31'd0, OERR}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (16) @(negedge clk);

    // table of frames, each read out afterwards
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, 1'b0, 0);
      check("vec_rcif_at_stop", {31'd0, cap_rcif_fall}, 32'd0);
      check("vec_rcif", {31'd0, cap_rcif}, 32'd1);
      check("vec_data", cap_data, {24'd0, vecs[v].exp_data});
      check("vec_ferr", {31'd0, cap_ferr}, {31'd0, vecs[v].exp_ferr});
      check("vec_oerr", {31'd0, cap_oerr}, 32'd0);
      pulse_rd();
      check("vec_rd_clears", {31'd0, RCIF}, 32'd0);
    end

    // line held low past the stop bit: 0x00 with FERR and no restart
    send_frame(8'h00, 1'b0, 1'b0, 256);
    check("break_data", cap_data, 32'd0);
    check("break_ferr", {31'd0, cap_ferr}, 32'd1);
    check("break_no_restart", {31'd0, hold_busy}, 32'd0);
    pulse_rd();

    // overrun: 0x11 then 0x22 unread
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    check("ovr_data", cap_data, 32'h11);
    check("ovr_oerr", {31'd0, cap_oerr}, 32'd1);
    check("ovr_rcif", {31'd0, cap_rcif}, 32'd1);
    busy_seen = 1'b0;
    send_frame(8'h44, 1'b1, 1'b0, 0);
    check("ovr_blocks_start", {31'd0, busy_seen}, 32'd0);
    check("ovr_data_kept", RX_data, 32'h11);
    CREN = 1'b0;
    @(negedge clk);
    CREN = 1'b1;
    check("ovr_cleared", {31'd0, OERR}, 32'd0);
    pulse_rd();
    send_frame(8'h33, 1'b1, 1'b0, 0);
    check("after_ovr_data", cap_data, 32'h33);
    check("after_ovr_rcif", {31'd0, cap_rcif}, 32'd1);
    check("after_ovr_oerr", {31'd0, cap_oerr}, 32'd0);
    pulse_rd();

    // 4-tick low glitch is a false start
    busy_seen = 1'b0;
    RX = 1'b0;
    repeat (16) @(negedge clk);
    RX = 1'b1;
    repeat (128) @(negedge clk);
    check("glitch_busy_pulse", {31'd0, busy_seen}, 32'd1);
    check("glitch_idle", {31'd0, busy}, 32'd0);
    check("glitch_rcif", {31'd0, RCIF}, 32'd0);

    // RD in the same clk as the transfer of 0x55
    send_frame(8'h12, 1'b1, 1'b0, 0);
    send_frame(8'h55, 1'b1, 1'b1, 0);
    check("coll_rcif_before", {31'd0, cap_rcif_fall}, 32'd1);
    check("coll_data", cap_data, 32'h55);
    check("coll_rcif", {31'd0, cap_rcif}, 32'd1);
    check("coll_oerr", {31'd0, cap_oerr}, 32'd0);
    pulse_rd();
    check("coll_rd_clears", {31'd0, RCIF}, 32'd0);
    pulse_rd();
    check("rd_empty_rcif", {31'd0, RCIF}, 32'd0);
    check("rd_empty_data", RX_data, 32'h55);

    // reset during data bit 4
    RX = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = i[0];
      repeat (64) @(negedge clk);
    end
    RX = 1'b1;
    repeat (32) @(negedge clk);
    check("mid_state_data", {30'd0, state_dbg}, 32'd2);
    #1 reset = 1'b1;
    #2;
    check("async_rst_data", RX_data, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_flags", {29'd0, RCIF, FERR, OERR}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (16) @(negedge clk);
    send_frame(8'h7E, 1'b1, 1'b0, 0);
    check("post_rst_data", cap_data, 32'h7E);
    check("post_rst_rcif", {31'd0, cap_rcif}, 32'd1);
    check("post_rst_ferr", {31'd0, cap_ferr}, 32'd0);

    // SPEN drop mid-frame aborts without touching the buffer
    RX = 1'b0;
    repeat (64) @(negedge clk);
    RX = 1'b0;
    repeat (64) @(negedge clk);
    RX = 1'b1;
    repeat (64) @(negedge clk);
    RX = 1'b0;
    repeat (64) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    SPEN = 1'b0;
    @(negedge clk);
    check("abort_idle", {31'd0, busy}, 32'd0);
    check("abort_data", RX_data, 32'h7E);
    check("abort_rcif", {31'd0, RCIF}, 32'd1);
    RX = 1'b1;
    SPEN = 1'b1;
    repeat (64) @(negedge clk);
    pulse_rd();
    send_frame(8'hC3, 1'b1, 1'b0, 0);
    check("after_abort_data", cap_data, 32'hC3);
    check("after_abort_rcif", {31'd0, cap_rcif}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
